// File: rtl/lrc_pkg.sv
// Shared definitions for the LRC generator/checker pair: state encoding,
// byte width and the LRC formula used by both ends of the link.
package lrc_pkg;

    localparam int unsigned LRC_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t PAYLOAD = 2'd1;
    localparam state_t CHECK   = 2'd2;

    // Two's complement of the running sum: adding it back to the sum gives zero.
    function automatic logic [LRC_W-1:0] lrc_of(input logic [LRC_W-1:0] sum);
        return (~sum) + LRC_W'(1);
    endfunction

endpackage

// File: rtl/lrc_checker_if.sv
// Byte-stream input and frame-status output bundle of the LRC checker.
interface lrc_checker_if import lrc_pkg::*; #(parameter int unsigned CNT_W = 8);

    logic [LRC_W-1:0] in_data;
    logic             in_valid;
    logic             flush;
    logic             busy;
    logic             done;
    logic             ok;
    logic             len_err;
    logic             to_err;
    logic [LRC_W-1:0] exp_lrc;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] bad_cnt;

    modport master (
        output in_data, in_valid, flush,
        input  busy, done, ok, len_err, to_err, exp_lrc, good_cnt, bad_cnt
    );

    modport slave (
        input  in_data, in_valid, flush,
        output busy, done, ok, len_err, to_err, exp_lrc, good_cnt, bad_cnt
    );

endinterface

// File: rtl/lrc_idle_timer.sv
// Counts consecutive idle cycles inside a frame; expire_o_c fires on the
// cycle whose edge would bring the count up to TIMEOUT.
module lrc_idle_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o_c
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire_o_c = en_i && !clear_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expire_o_c) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lrc_checker.sv
// Receive-side LRC checker: parses length-prefixed frames, verifies the
// trailing LRC byte and keeps saturating good/bad frame counters.
module lrc_checker import lrc_pkg::*; #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    lrc_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [LRC_W-1:0] sum_q, sum_d;
    logic [LRC_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic             len_err_q, len_err_d;
    logic             to_err_q, to_err_d;
    logic [LRC_W-1:0] exp_lrc_q, exp_lrc_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] bad_q, bad_d;

    logic             good_inc_c;
    logic             bad_inc_c;
    logic             timeout_c;
    logic [LRC_W-1:0] lrc_sum_c;

    assign lrc_sum_c = sum_q + bus.in_data;

    lrc_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (bus.flush || bus.in_valid || (state_q == IDLE)),
        .en_i       (state_q != IDLE),
        .expire_o_c (timeout_c)
    );

    // Frame parser; flush overrides both byte acceptance and timeout.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        len_err_d  = 1'b0;
        to_err_d   = 1'b0;
        exp_lrc_d  = exp_lrc_q;
        good_inc_c = 1'b0;
        bad_inc_c  = 1'b0;

        if (bus.flush) begin
            state_d = IDLE;
            sum_d   = '0;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_data == '0) begin
                            done_d    = 1'b1;
                            len_err_d = 1'b1;
                            ok_d      = 1'b0;
                            bad_inc_c = 1'b1;
                        end else begin
                            rem_d   = bus.in_data;
                            sum_d   = '0;
                            state_d = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (bus.in_valid) begin
                        sum_d = lrc_sum_c;
                        rem_d = rem_q - LRC_W'(1);
                        if (rem_q == LRC_W'(1)) begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (bus.in_valid) begin
                        done_d     = 1'b1;
                        ok_d       = (lrc_sum_c == '0);
                        exp_lrc_d  = lrc_of(sum_q);
                        good_inc_c = (lrc_sum_c == '0);
                        bad_inc_c  = (lrc_sum_c != '0);
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Abort with the partial-sum LRC so the far end can be diagnosed.
            if (timeout_c) begin
                done_d    = 1'b1;
                to_err_d  = 1'b1;
                ok_d      = 1'b0;
                exp_lrc_d = lrc_of(sum_q);
                bad_inc_c = 1'b1;
                state_d   = IDLE;
            end
        end

        good_d = good_q;
        bad_d  = bad_q;
        if (good_inc_c && (good_q != CNT_MAX)) begin
            good_d = good_q + CNT_W'(1);
        end
        if (bad_inc_c && (bad_q != CNT_MAX)) begin
            bad_d = bad_q + CNT_W'(1);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sum_q     <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            len_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            exp_lrc_q <= '0;
            good_q    <= '0;
            bad_q     <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
            len_err_q <= len_err_d;
            to_err_q  <= to_err_d;
            exp_lrc_q <= exp_lrc_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ok       = ok_q;
    assign bus.len_err  = len_err_q;
    assign bus.to_err   = to_err_q;
    assign bus.exp_lrc  = exp_lrc_q;
    assign bus.good_cnt = good_q;
    assign bus.bad_cnt  = bad_q;

endmodule

// File: tb/tb_lrc_checker.sv
// Bench for lrc_checker: two instances (8-bit and 2-bit counters) share one
// byte stream; expectations come from frame-level arithmetic on the bytes sent.
module tb_lrc_checker;
    import lrc_pkg::*;

    localparam int unsigned TO = 4;

    localparam int K_CHK = 0;
    localparam int K_LEN = 1;
    localparam int K_TO  = 2;

    logic clk = 1'b0;
    logic rst_n;

    lrc_checker_if #(.CNT_W(8)) bus_a ();
    lrc_checker_if #(.CNT_W(2)) bus_b ();

    lrc_checker #(.TIMEOUT(TO), .CNT_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    lrc_checker #(.TIMEOUT(TO), .CNT_W(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Expected status after the next sampled edge
    bit         e_busy, e_done, e_ok, e_len, e_to, e_lrc_known;
    logic [7:0] e_lrc;
    int         e_good, e_bad;
    logic [7:0] pbuf [256];

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy_a",    32'(bus_a.busy),     32'(e_busy));
        chk("done_a",    32'(bus_a.done),     32'(e_done));
        chk("ok_a",      32'(bus_a.ok),       32'(e_ok));
        chk("len_err_a", 32'(bus_a.len_err),  32'(e_len));
        chk("to_err_a",  32'(bus_a.to_err),   32'(e_to));
        chk("good_a",    32'(bus_a.good_cnt), 32'(sat(e_good, 8)));
        chk("bad_a",     32'(bus_a.bad_cnt),  32'(sat(e_bad, 8)));
        chk("done_b",    32'(bus_b.done),     32'(e_done));
        chk("ok_b",      32'(bus_b.ok),       32'(e_ok));
        chk("good_b",    32'(bus_b.good_cnt), 32'(sat(e_good, 2)));
        chk("bad_b",     32'(bus_b.bad_cnt),  32'(sat(e_bad, 2)));
        if (e_lrc_known) begin
            chk("exp_lrc_a", 32'(bus_a.exp_lrc), 32'(e_lrc));
            chk("exp_lrc_b", 32'(bus_b.exp_lrc), 32'(e_lrc));
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit f);
        bus_a.in_valid = v;  bus_a.in_data = d;  bus_a.flush = f;
        bus_b.in_valid = v;  bus_b.in_data = d;  bus_b.flush = f;
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit f, input bit busy);
        drive(v, d, f);
        e_busy = busy;
        @(posedge clk);
        #1;
        check_all();
        e_done = 1'b0;
        e_len  = 1'b0;
        e_to   = 1'b0;
    endtask

    // Frame outcome from the bytes alone: pass iff payload sum plus LRC is 0 mod 256.
    task automatic set_result(input int kind, input int sum, input int lrc);
        int s8;
        s8     = sum % 256;
        e_done = 1'b1;
        e_len  = (kind == K_LEN);
        e_to   = (kind == K_TO);
        e_ok   = (kind == K_CHK) && (((s8 + lrc) % 256) == 0);
        if (kind == K_LEN) begin
            e_lrc_known = 1'b0;
        end else begin
            e_lrc       = 8'((256 - s8) % 256);
            e_lrc_known = 1'b1;
        end
        if (e_ok) e_good++;
        else      e_bad++;
    endtask

    task automatic send_len0();
        set_result(K_LEN, 0, 0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int len, input logic [7:0] lrc, input int gap);
        int s;
        s = 0;
        cyc(1'b1, 8'(len), 1'b0, 1'b1);
        for (int i = 0; i < len; i++) begin
            repeat (gap) cyc(1'b0, 8'h00, 1'b0, 1'b1);
            s += int'(pbuf[i]);
            cyc(1'b1, pbuf[i], 1'b0, 1'b1);
        end
        repeat (gap) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        set_result(K_CHK, s, int'(lrc));
        cyc(1'b1, lrc, 1'b0, 1'b0);
    endtask

    task automatic timeout_frame(input int len, input int k);
        int s;
        s = 0;
        cyc(1'b1, 8'(len), 1'b0, 1'b1);
        for (int i = 0; i < k; i++) begin
            s += int'(pbuf[i]);
            cyc(1'b1, pbuf[i], 1'b0, 1'b1);
        end
        repeat (TO - 1) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        set_result(K_TO, s, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic flush_frame(input int len, input int k);
        cyc(1'b1, 8'(len), 1'b0, 1'b1);
        for (int i = 0; i < k; i++) cyc(1'b1, pbuf[i], 1'b0, 1'b1);
        cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
    endtask

    function automatic logic [7:0] good_lrc(input int len);
        int s;
        s = 0;
        for (int i = 0; i < len; i++) s += int'(pbuf[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) pbuf[i] = 8'($urandom);
    endtask

    task automatic check_reset_state();
        chk("rst_busy",    32'(bus_a.busy),     32'(0));
        chk("rst_done",    32'(bus_a.done),     32'(0));
        chk("rst_ok",      32'(bus_a.ok),       32'(0));
        chk("rst_len_err", 32'(bus_a.len_err),  32'(0));
        chk("rst_to_err",  32'(bus_a.to_err),   32'(0));
        chk("rst_exp_lrc", 32'(bus_a.exp_lrc),  32'(0));
        chk("rst_good",    32'(bus_a.good_cnt), 32'(0));
        chk("rst_bad",     32'(bus_a.bad_cnt),  32'(0));
        chk("rst_good_b",  32'(bus_b.good_cnt), 32'(0));
        chk("rst_bad_b",   32'(bus_b.bad_cnt),  32'(0));
    endtask

    task automatic model_reset();
        e_busy = 1'b0;  e_done = 1'b0;  e_ok = 1'b0;  e_len = 1'b0;  e_to = 1'b0;
        e_lrc = 8'h00;  e_lrc_known = 1'b1;  e_good = 0;  e_bad = 0;
    endtask

    initial begin
        int kind, len, gap;
        drive(1'b0, 8'h00, 1'b0);
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_state();
        #9 rst_n = 1'b1;

        // 3-byte frame, correct LRC
        pbuf[0] = 8'h01;  pbuf[1] = 8'h02;  pbuf[2] = 8'h03;
        send_frame(3, 8'hFA, 0);
        // Same payload, wrong LRC, then a 1-byte frame with no gap cycle
        send_frame(3, 8'hFB, 0);
        pbuf[0] = 8'h80;
        send_frame(1, 8'h80, 0);

        // Zero length byte followed by a normal frame
        send_len0();
        fill_random(4);
        send_frame(4, good_lrc(4), 1);

        // Timeout in PAYLOAD, right after the length byte and in CHECK
        pbuf[0] = 8'h10;
        timeout_frame(2, 1);
        fill_random(3);
        timeout_frame(3, 0);
        timeout_frame(3, 3);
        // Longest tolerated gap keeps the frame alive
        fill_random(4);
        send_frame(4, good_lrc(4), TO - 1);

        // Flush with a valid byte in PAYLOAD and in CHECK
        fill_random(5);
        flush_frame(5, 2);
        send_frame(5, good_lrc(5), 0);
        flush_frame(2, 2);
        pbuf[0] = 8'h33;
        send_frame(1, 8'hCD, 0);

        // Asynchronous reset mid-frame
        cyc(1'b1, 8'd6, 1'b0, 1'b1);
        cyc(1'b1, 8'h55, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_state();
        model_reset();
        #3 rst_n = 1'b1;

        // Five passing frames drive the 2-bit counter into saturation
        for (int f = 0; f < 5; f++) begin
            len = int'($urandom_range(1, 6));
            fill_random(len);
            send_frame(len, good_lrc(len), 0);
        end

        // Random mix of frame kinds
        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 12));
            gap  = int'($urandom_range(0, TO - 1));
            fill_random(len);
            if (kind == 0) begin
                send_len0();
            end else if (kind == 1) begin
                timeout_frame(len, int'($urandom_range(0, len)));
            end else if (kind == 2) begin
                flush_frame(len, int'($urandom_range(0, len)));
            end else if (kind < 6) begin
                send_frame(len, 8'($urandom), gap);
            end else begin
                send_frame(len, good_lrc(len), gap);
            end
        end

        repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
